// File: rtl/riscv_bus_pkg.sv
// Shared bus definitions for the core's data-memory path.
// Contents:
//   dmem_state_t   router state encoding (IDLE, FWD, WAIT, RESP)
//   TGT_RAM/MMIO   target select encoding
//   DEF_MMIO_*     default MMIO window decode constants
//   decode_tgt()   address -> target select
package riscv_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } dmem_state_t;

  localparam logic TGT_RAM  = 1'b0;
  localparam logic TGT_MMIO = 1'b1;

  localparam logic [31:0] DEF_MMIO_BASE = 32'h1000_0000;
  localparam logic [31:0] DEF_MMIO_MASK = 32'hF000_0000;

  function automatic logic decode_tgt(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] mask);
    return ((addr & mask) == base) ? TGT_MMIO : TGT_RAM;
  endfunction

endpackage

// File: rtl/dmem_timeout_ctr.sv
// Cycle counter bounding how long a forwarded request may wait for its target.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clear       zero the count (takes priority over enable)
//   enable      count this cycle
//   expired     count has reached TIMEOUT-1
module dmem_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Saturate at the limit so the count never wraps back below it.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_demux.sv
// Single-outstanding data-memory router: core port -> RAM (target 0) or
// MMIO window (target 1). Misaligned accesses and target timeouts are
// answered locally with resp_err=1.
// Ports:
//   req_*        core request handshake (addr/we/wstrb/wdata)
//   resp_*       core response handshake (rdata/err)
//   t0_*, t1_*   per-target request handshake, registered request copy,
//                single-cycle response pulse with load data
module dmem_demux
  import riscv_bus_pkg::*;
#(
  parameter logic [31:0] MMIO_BASE = DEF_MMIO_BASE,
  parameter logic [31:0] MMIO_MASK = DEF_MMIO_MASK,
  parameter int          TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        t0_req_valid,
  input  logic        t0_req_ready,
  output logic [31:0] t0_addr,
  output logic        t0_we,
  output logic [3:0]  t0_wstrb,
  output logic [31:0] t0_wdata,
  input  logic        t0_resp_valid,
  input  logic [31:0] t0_resp_rdata,
  output logic        t1_req_valid,
  input  logic        t1_req_ready,
  output logic [31:0] t1_addr,
  output logic        t1_we,
  output logic [3:0]  t1_wstrb,
  output logic [31:0] t1_wdata,
  input  logic        t1_resp_valid,
  input  logic [31:0] t1_resp_rdata
);

  dmem_state_t state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic        sel_q, sel_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic ctr_clear, ctr_en, expired;
  logic tsel_req_ready, tsel_resp_valid;
  logic [31:0] tsel_resp_rdata;

  dmem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (ctr_clear),
    .enable (ctr_en),
    .expired(expired)
  );

  // Only the selected target's handshake and response are ever observed.
  assign tsel_req_ready  = (sel_q == TGT_MMIO) ? t1_req_ready  : t0_req_ready;
  assign tsel_resp_valid = (sel_q == TGT_MMIO) ? t1_resp_valid : t0_resp_valid;
  assign tsel_resp_rdata = (sel_q == TGT_MMIO) ? t1_resp_rdata : t0_resp_rdata;

  assign req_ready    = (state_q == IDLE);
  assign resp_valid   = (state_q == RESP);
  assign resp_rdata   = rdata_q;
  assign resp_err     = err_q;
  assign t0_req_valid = (state_q == FWD) && (sel_q == TGT_RAM);
  assign t1_req_valid = (state_q == FWD) && (sel_q == TGT_MMIO);

  // Both targets see the same latched request; only req_valid is steered.
  assign t0_addr  = addr_q;
  assign t0_we    = we_q;
  assign t0_wstrb = wstrb_q;
  assign t0_wdata = wdata_q;
  assign t1_addr  = addr_q;
  assign t1_we    = we_q;
  assign t1_wstrb = wstrb_q;
  assign t1_wdata = wdata_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wstrb_d   = wstrb_q;
    wdata_d   = wdata_q;
    sel_d     = sel_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    ctr_clear = 1'b0;
    ctr_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          we_d    = req_we;
          wstrb_d = req_wstrb;
          wdata_d = req_wdata;
          if (req_addr[1:0] != 2'b00) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            sel_d     = decode_tgt(req_addr, MMIO_BASE, MMIO_MASK);
            ctr_clear = 1'b1;
            state_d   = FWD;
          end
        end
      end
      FWD: begin
        ctr_en = 1'b1;
        // A handshake on the expiring cycle still loses: no response can follow.
        if (expired) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else if (tsel_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        ctr_en = 1'b1;
        // A response arriving on the expiring cycle is still honoured.
        if (tsel_resp_valid) begin
          rdata_d = we_q ? 32'h0 : tsel_resp_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (expired) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wstrb_q <= '0;
      wdata_q <= '0;
      sel_q   <= TGT_RAM;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dmem_demux.sv
module tb_dmem_demux;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        t0_req_valid, t0_req_ready, t0_we, t0_resp_valid;
  logic [31:0] t0_addr, t0_wdata, t0_resp_rdata;
  logic [3:0]  t0_wstrb;
  logic        t1_req_valid, t1_req_ready, t1_we, t1_resp_valid;
  logic [31:0] t1_addr, t1_wdata, t1_resp_rdata;
  logic [3:0]  t1_wstrb;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_demux #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .t0_req_valid(t0_req_valid), .t0_req_ready(t0_req_ready),
    .t0_addr(t0_addr), .t0_we(t0_we), .t0_wstrb(t0_wstrb), .t0_wdata(t0_wdata),
    .t0_resp_valid(t0_resp_valid), .t0_resp_rdata(t0_resp_rdata),
    .t1_req_valid(t1_req_valid), .t1_req_ready(t1_req_ready),
    .t1_addr(t1_addr), .t1_we(t1_we), .t1_wstrb(t1_wstrb), .t1_wdata(t1_wdata),
    .t1_resp_valid(t1_resp_valid), .t1_resp_rdata(t1_resp_rdata)
  );

  task automatic idle_inputs();
    req_valid = 0; req_addr = 0; req_we = 0; req_wstrb = 0; req_wdata = 0;
    resp_ready = 0;
    t0_req_ready = 0; t0_resp_valid = 0; t0_resp_rdata = 0;
    t1_req_ready = 0; t1_resp_valid = 0; t1_resp_rdata = 0;
  endtask

  // One complete transaction. r: FWD cycles before the target asserts ready;
  // d: cycles in WAIT before the response pulse (<0: never); hold: cycles
  // resp_ready stays low once resp_valid is seen. Non-selected targets emit
  // random spurious response pulses throughout.
  task automatic run_txn(input string name, input logic [31:0] addr, input logic we,
                         input logic [3:0] wstrb, input logic [31:0] wdata,
                         input int r, input int d, input logic [31:0] trd, input int hold);
    logic mis, sel, exp_err, exp_v, sv, ov, seen, done;
    logic [31:0] exp_rd, sa;
    logic [3:0] sst;
    logic [31:0] sd;
    logic sw;
    int k, exp_cyc, c0;
    mis = (addr[1:0] != 2'b00);
    sel = ((addr & 32'hF000_0000) == 32'h1000_0000);
    k = 2 + r + d;
    if (mis) begin
      exp_cyc = 1; exp_err = 1; exp_rd = 0;
    end else if (d >= 0 && k <= TO) begin
      exp_cyc = k + 1; exp_err = 0; exp_rd = we ? 32'h0 : trd;
    end else begin
      exp_cyc = TO + 1; exp_err = 1; exp_rd = 0;
    end
    @(negedge clk);
    req_valid = 1; req_addr = addr; req_we = we; req_wstrb = wstrb; req_wdata = wdata;
    resp_ready = 0;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL %s req_ready_idle: got %b want 1", name, req_ready);
    end
    seen = 0; done = 0; c0 = 0;
    for (int c = 1; c <= 60 && !done; c++) begin
      @(posedge clk); #1;
      req_valid = 0;
      t0_resp_valid = ($urandom % 4) == 0; t0_resp_rdata = $urandom;
      t1_resp_valid = ($urandom % 4) == 0; t1_resp_rdata = $urandom;
      t0_req_ready = $urandom; t1_req_ready = $urandom;
      if (!mis) begin
        if (sel) begin
          t1_req_ready = (c >= 1 + r);
          t1_resp_valid = (d >= 0 && c == k); t1_resp_rdata = trd;
        end else begin
          t0_req_ready = (c >= 1 + r);
          t0_resp_valid = (d >= 0 && c == k); t0_resp_rdata = trd;
        end
      end
      @(negedge clk);
      exp_v = !mis && c <= 1 + r && c <= TO;
      sv = sel ? t1_req_valid : t0_req_valid;
      ov = sel ? t0_req_valid : t1_req_valid;
      checks++;
      if (sv !== exp_v || ov !== 1'b0) begin
        failures++;
        $display("FAIL %s tgt_valid c=%0d: sel=%b other=%b want sel=%b other=0", name, c, sv, ov, exp_v);
      end
      if (exp_v) begin
        sa = sel ? t1_addr : t0_addr; sw = sel ? t1_we : t0_we;
        sst = sel ? t1_wstrb : t0_wstrb; sd = sel ? t1_wdata : t0_wdata;
        checks++;
        if (sa !== addr || sw !== we || sst !== wstrb || sd !== wdata) begin
          failures++;
          $display("FAIL %s tgt_req: got %h/%b/%h/%h want %h/%b/%h/%h", name, sa, sw, sst, sd, addr, we, wstrb, wdata);
        end
      end
      if (!seen) begin
        if (resp_valid === 1'b1) begin
          seen = 1; c0 = c;
          checks++;
          if (c !== exp_cyc || resp_err !== exp_err || resp_rdata !== exp_rd || req_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s resp: cyc=%0d err=%b rdata=%h rr=%b want cyc=%0d err=%b rdata=%h rr=0",
                     name, c, resp_err, resp_rdata, req_ready, exp_cyc, exp_err, exp_rd);
          end
        end
      end else if (c <= c0 + hold) begin
        checks++;
        if (resp_valid !== 1'b1 || resp_err !== exp_err || resp_rdata !== exp_rd || req_ready !== 1'b0) begin
          failures++;
          $display("FAIL %s resp_hold c=%0d: v=%b err=%b rdata=%h rr=%b want v=1 err=%b rdata=%h rr=0",
                   name, c, resp_valid, resp_err, resp_rdata, req_ready, exp_err, exp_rd);
        end
      end else begin
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
          failures++;
          $display("FAIL %s return_idle: resp_valid=%b req_ready=%b want 0/1", name, resp_valid, req_ready);
        end
        done = 1;
      end
      resp_ready = seen && (c >= c0 + hold) && !done;
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL %s no_response: resp_valid never seen, want cycle %0d", name, exp_cyc);
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1 || resp_valid !== 0 || resp_err !== 0 || resp_rdata !== 0 ||
        t0_req_valid !== 0 || t1_req_valid !== 0) begin
      failures++;
      $display("FAIL reset_state: rr=%b rv=%b err=%b rd=%h t0v=%b t1v=%b want 1/0/0/0/0/0",
               req_ready, resp_valid, resp_err, resp_rdata, t0_req_valid, t1_req_valid);
    end
    rst_n = 1;
  endtask

  task automatic test_store_ram();
    run_txn("store_ram", 32'h0000_0100, 1'b1, 4'hF, 32'hA5A5_A5A5, 1, 2, 32'hDEAD_BEEF, 0);
  endtask

  task automatic test_load_mmio();
    run_txn("load_mmio", 32'h1000_0004, 1'b0, 4'h0, 32'h0, 0, 0, 32'h1234_5678, 0);
  endtask

  task automatic test_misaligned();
    run_txn("misaligned", 32'h0000_0102, 1'b0, 4'h0, 32'h0, 0, 0, 32'h5555_5555, 0);
  endtask

  task automatic test_timeout();
    run_txn("timeout", 32'h1000_0040, 1'b0, 4'h0, 32'h0, 0, 18, 32'h7777_7777, 1);
    run_txn("resp_on_last", 32'h0000_0040, 1'b0, 4'h0, 32'h0, 0, 14, 32'h0BAD_F00D, 0);
  endtask

  task automatic test_backpressure();
    run_txn("backpressure", 32'h1000_0008, 1'b0, 4'h0, 32'h0, 2, 1, 32'hCAFE_0001, 5);
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    req_valid = 1; req_addr = 32'h0000_0200; req_we = 0; req_wstrb = 0; req_wdata = 0;
    @(posedge clk); #1;
    req_valid = 0; t0_req_ready = 1;
    repeat (2) @(posedge clk);
    #2 rst_n = 0;
    #1;
    checks++;
    if (t0_req_valid !== 0 || t1_req_valid !== 0 || resp_valid !== 0 || req_ready !== 1) begin
      failures++;
      $display("FAIL reset_in_wait: t0v=%b t1v=%b rv=%b rr=%b want 0/0/0/1",
               t0_req_valid, t1_req_valid, resp_valid, req_ready);
    end
    t0_resp_valid = 1;
    @(negedge clk);
    checks++;
    if (resp_valid !== 0 || req_ready !== 1) begin
      failures++;
      $display("FAIL reset_hold: rv=%b rr=%b want 0/1", resp_valid, req_ready);
    end
    idle_inputs();
    rst_n = 1;
    run_txn("after_reset", 32'h0000_0300, 1'b0, 4'h0, 32'h0, 0, 1, 32'h0101_0202, 0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    int d;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if ($urandom % 3 == 0) a = {4'h1, a[27:0]};
      if ($urandom % 5 != 0) a[1:0] = 2'b00;
      d = ($urandom % 5 == 0) ? -1 : int'($urandom_range(0, 18));
      run_txn("random", a, 1'($urandom), 4'($urandom), $urandom,
              int'($urandom_range(0, 5)), d, $urandom, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_store_ram();
    test_load_mmio();
    test_misaligned();
    test_timeout();
    test_backpressure();
    test_reset_in_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
